// File: rtl/decode_pkg.sv
// ============================================================================
// Module   : decode_pkg
// Brief    : Shared widths, types and index helpers for the decode stage.
// Revision : 1.0 - pipelined decode with scoreboard and write-back bypass
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_IDX_W    = 5;
    localparam int MAX_REGS     = 1 << REG_IDX_W;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Operand bundle handed to execute, at the default datapath width.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] rd1;
        logic [XLEN_DEFAULT-1:0] rd2;
        reg_idx_t                rd;
        logic                    wr_en;
        logic                    illegal;
        logic [XLEN_DEFAULT-1:0] pc;
    } dec_out_t;

    function automatic logic idx_legal(input reg_idx_t idx, input int nregs);
        return int'(idx) < nregs;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_pipe_reg_file.sv
// ============================================================================
// Module   : reg_file
// Brief    : Two-read, one-write architectural register file; x0 reads as 0.
// Revision : 1.0 - re-parametrised by XLEN/NREGS
// ============================================================================
`default_nettype none

module reg_file
    import decode_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            we,
    input  reg_idx_t        waddr,
    input  logic [XLEN-1:0] wdata,
    input  reg_idx_t        raddr1,
    input  reg_idx_t        raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    localparam int c_IDX_W = $clog2(NREGS);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (we && waddr != '0 && idx_legal(waddr, NREGS)) begin
            r_mem[waddr[c_IDX_W-1:0]] <= wdata;
        end
    end

    // Entry 0 is never written, so it is masked on the read side instead.
    assign rdata1 = (raddr1 == '0 || !idx_legal(raddr1, NREGS)) ? '0 : r_mem[raddr1[c_IDX_W-1:0]];
    assign rdata2 = (raddr2 == '0 || !idx_legal(raddr2, NREGS)) ? '0 : r_mem[raddr2[c_IDX_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/decode_pipe_scoreboard.sv
// ============================================================================
// Module   : scoreboard
// Brief    : Per-register pending-write bits; a set beats a same-cycle clear.
// Revision : 1.0 - pipelined decode with scoreboard and write-back bypass
// ============================================================================
`default_nettype none

module scoreboard
    import decode_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  reg_idx_t         set_idx,
    input  logic             clr_en,
    input  reg_idx_t         clr_idx,
    input  logic             flush_clr_en,
    input  reg_idx_t         flush_clr_idx,
    output logic [NREGS-1:0] busy
);

    logic [MAX_REGS-1:0] w_set_ext;
    logic [MAX_REGS-1:0] w_clr_ext;
    logic [NREGS-1:0]    w_next;
    logic [NREGS-1:0]    r_busy;

    always_comb begin
        w_set_ext = '0;
        w_clr_ext = '0;
        if (set_en)       w_set_ext[set_idx]       = 1'b1;
        if (clr_en)       w_clr_ext[clr_idx]       = 1'b1;
        if (flush_clr_en) w_clr_ext[flush_clr_idx] = 1'b1;
        w_next    = (r_busy & ~w_clr_ext[NREGS-1:0]) | w_set_ext[NREGS-1:0];
        w_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_next;
        end
    end

    assign busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/decode_pipe.sv
// ============================================================================
// Module   : decode_pipe
// Brief    : Pipelined decode: register read, RAW/WAW interlock, optional
//            write-back bypass and a valid/ready output register to execute.
// Revision : 1.0 - successor to the multi-cycle decode stage
// ============================================================================
`default_nettype none

module decode_pipe
    import decode_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  reg_idx_t        in_rs1,
    input  reg_idx_t        in_rs2,
    input  reg_idx_t        in_rd,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic            in_wr_en,
    input  logic            in_nop,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output reg_idx_t        out_rd,
    output logic            out_wr_en,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc,
    input  logic            wb_en,
    input  reg_idx_t        wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0]    w_busy;
    logic [MAX_REGS-1:0] w_busy_ext;
    logic                w_rs1_legal, w_rs2_legal, w_rd_legal, w_wb_legal;
    logic                w_byp1, w_byp2;
    logic                w_hazard, w_ready, w_acc, w_load, w_illegal;
    logic                w_sb_set, w_sb_flush_clr;
    logic [XLEN-1:0]     w_rf_rd1, w_rf_rd2, w_op1, w_op2;

    logic                r_out_valid;
    logic [XLEN-1:0]     r_out_rd1, r_out_rd2, r_out_pc;
    reg_idx_t            r_out_rd;
    logic                r_out_wr_en, r_out_illegal;

    // Zero-extend so any 5-bit index can probe the scoreboard safely.
    if (NREGS < MAX_REGS) begin : g_busy_pad
        assign w_busy_ext = {{(MAX_REGS-NREGS){1'b0}}, w_busy};
    end else begin : g_busy_full
        assign w_busy_ext = w_busy;
    end

    assign w_rs1_legal = idx_legal(in_rs1, NREGS);
    assign w_rs2_legal = idx_legal(in_rs2, NREGS);
    assign w_rd_legal  = idx_legal(in_rd, NREGS);
    assign w_wb_legal  = idx_legal(wb_addr, NREGS);

    assign w_byp1 = (BYPASS != 0) && wb_en && (wb_addr == in_rs1);
    assign w_byp2 = (BYPASS != 0) && wb_en && (wb_addr == in_rs2);

    assign w_hazard = !in_nop && (
           (in_use_rs1 && in_rs1 != '0 && w_busy_ext[in_rs1] && !w_byp1)
        || (in_use_rs2 && in_rs2 != '0 && w_busy_ext[in_rs2] && !w_byp2)
        || (in_wr_en   && in_rd  != '0 && w_busy_ext[in_rd]));

    assign w_ready  = (!r_out_valid || out_ready) && !w_hazard && !flush;
    assign w_acc    = in_valid && w_ready;
    assign w_load   = w_acc && !in_nop;
    assign in_ready = w_ready;

    assign w_illegal = (in_use_rs1 && !w_rs1_legal)
                    || (in_use_rs2 && !w_rs2_legal)
                    || (in_wr_en   && !w_rd_legal);

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk    (clk),
        .we     (wb_en && !rst),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (in_rs1),
        .raddr2 (in_rs2),
        .rdata1 (w_rf_rd1),
        .rdata2 (w_rf_rd2)
    );

    assign w_op1 = (in_rs1 == '0 || !w_rs1_legal) ? '0 : w_byp1 ? wb_data : w_rf_rd1;
    assign w_op2 = (in_rs2 == '0 || !w_rs2_legal) ? '0 : w_byp2 ? wb_data : w_rf_rd2;

    // A flushed writer never reaches write-back, so its pending bit is released here.
    assign w_sb_set       = w_load && in_wr_en && in_rd != '0 && !w_illegal;
    assign w_sb_flush_clr = flush && r_out_valid && r_out_wr_en && r_out_rd != '0
                         && idx_legal(r_out_rd, NREGS);

    scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .set_en        (w_sb_set),
        .set_idx       (in_rd),
        .clr_en        (wb_en && w_wb_legal),
        .clr_idx       (wb_addr),
        .flush_clr_en  (w_sb_flush_clr),
        .flush_clr_idx (r_out_rd),
        .busy          (w_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_rd1     <= '0;
            r_out_rd2     <= '0;
            r_out_rd      <= '0;
            r_out_wr_en   <= 1'b0;
            r_out_illegal <= 1'b0;
            r_out_pc      <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_out_rd1     <= w_op1;
            r_out_rd2     <= w_op2;
            r_out_rd      <= in_rd;
            r_out_wr_en   <= in_wr_en;
            r_out_illegal <= w_illegal;
            r_out_pc      <= in_pc;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_rd1     = r_out_rd1;
    assign out_rd2     = r_out_rd2;
    assign out_rd      = r_out_rd;
    assign out_wr_en   = r_out_wr_en;
    assign out_illegal = r_out_illegal;
    assign out_pc      = r_out_pc;
    assign busy        = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_decode_pipe.sv
// ============================================================================
// Module   : tb_decode_pipe
// Brief    : Two decode_pipe configurations (32 regs + bypass, 16 regs no
//            bypass) sharing one stimulus stream, checked against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_use_rs1, in_use_rs2, in_wr_en, in_nop;
    logic [4:0]  in_rs1, in_rs2, in_rd, wb_addr;
    logic [31:0] in_pc, wb_data;
    logic        out_ready, wb_en, flush;

    logic        ready_a, ov_a, wr_a, ill_a;
    logic [31:0] rd1_a, rd2_a, pc_a, busy_a;
    logic [4:0]  ord_a;
    logic        ready_b, ov_b, wr_b, ill_b;
    logic [31:0] rd1_b, rd2_b, pc_b;
    logic [15:0] busy_b;
    logic [4:0]  ord_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per configuration: 0 = NREGS 32/BYPASS 1, 1 = NREGS 16/BYPASS 0.
    logic [31:0] m_reg [2][32];
    logic [31:0] m_busy [2];
    logic        m_ov [2], m_wr [2], m_ill [2];
    logic [31:0] m_rd1 [2], m_rd2 [2], m_pc [2];
    logic [4:0]  m_rd [2];

    always #5 clk = ~clk;

    decode_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_en(in_wr_en),
        .in_nop(in_nop), .in_pc(in_pc), .out_valid(ov_a), .out_ready(out_ready),
        .out_rd1(rd1_a), .out_rd2(rd2_a), .out_rd(ord_a), .out_wr_en(wr_a),
        .out_illegal(ill_a), .out_pc(pc_a), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .busy(busy_a)
    );

    decode_pipe #(.XLEN(32), .NREGS(16), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_en(in_wr_en),
        .in_nop(in_nop), .in_pc(in_pc), .out_valid(ov_b), .out_ready(out_ready),
        .out_rd1(rd1_b), .out_rd2(rd2_b), .out_rd(ord_b), .out_wr_en(wr_b),
        .out_illegal(ill_b), .out_pc(pc_b), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cfg_nregs(input int c);
        return (c == 0) ? 32 : 16;
    endfunction

    function automatic logic model_ready(input int c);
        logic byp, hz;
        byp = (c == 0);
        hz  = 1'b0;
        if (!in_nop) begin
            if (in_use_rs1 && in_rs1 != 0 && m_busy[c][in_rs1] && !(byp && wb_en && wb_addr == in_rs1)) hz = 1'b1;
            if (in_use_rs2 && in_rs2 != 0 && m_busy[c][in_rs2] && !(byp && wb_en && wb_addr == in_rs2)) hz = 1'b1;
            if (in_wr_en && in_rd != 0 && m_busy[c][in_rd]) hz = 1'b1;
        end
        return (!m_ov[c] || out_ready) && !hz && !flush;
    endfunction

    function automatic logic [31:0] model_operand(input int c, input logic [4:0] rs);
        if (rs == 0 || int'(rs) >= cfg_nregs(c)) return 32'h0;
        if (c == 0 && wb_en && wb_addr == rs) return wb_data;
        return m_reg[c][rs];
    endfunction

    task automatic model_reset(input int c);
        m_ov[c]   = 1'b0; m_wr[c]  = 1'b0; m_ill[c] = 1'b0;
        m_rd1[c]  = '0;   m_rd2[c] = '0;   m_pc[c]  = '0;
        m_rd[c]   = '0;   m_busy[c] = '0;
    endtask

    task automatic model_step(input int c);
        int          n;
        logic        acc, ill;
        logic [31:0] b, op1, op2;
        n = cfg_nregs(c);
        if (rst) begin
            model_reset(c);
            return;
        end
        acc = in_valid && model_ready(c);
        ill = (in_use_rs1 && int'(in_rs1) >= n) || (in_use_rs2 && int'(in_rs2) >= n)
           || (in_wr_en && int'(in_rd) >= n);
        op1 = model_operand(c, in_rs1);
        op2 = model_operand(c, in_rs2);
        b = m_busy[c];
        if (wb_en && int'(wb_addr) < n) b[wb_addr] = 1'b0;
        if (flush && m_ov[c] && m_wr[c] && m_rd[c] != 0) b[m_rd[c]] = 1'b0;
        if (acc && !in_nop && in_wr_en && in_rd != 0 && !ill) b[in_rd] = 1'b1;
        m_busy[c] = b;
        if (wb_en && wb_addr != 0 && int'(wb_addr) < n) m_reg[c][wb_addr] = wb_data;
        if (flush) begin
            m_ov[c] = 1'b0;
        end else if (acc && !in_nop) begin
            m_ov[c] = 1'b1; m_rd1[c] = op1; m_rd2[c] = op2; m_pc[c] = in_pc;
            m_rd[c] = in_rd; m_wr[c] = in_wr_en; m_ill[c] = ill;
        end else if (out_ready) begin
            m_ov[c] = 1'b0;
        end
    endtask

    task automatic cmp_cfg(input int c, input logic rdy, input logic ov,
                           input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [4:0] rd, input logic wr, input logic ill,
                           input logic [31:0] pc, input logic [31:0] bsy);
        string s;
        s = (c == 0) ? "a" : "b";
        chk({s, ".in_ready"},  32'(rdy), 32'(model_ready(c)));
        chk({s, ".out_valid"}, 32'(ov),  32'(m_ov[c]));
        chk({s, ".busy"},      bsy,      m_busy[c]);
        if (m_ov[c]) begin
            chk({s, ".out_rd1"},     rd1,     m_rd1[c]);
            chk({s, ".out_rd2"},     rd2,     m_rd2[c]);
            chk({s, ".out_rd"},      32'(rd), 32'(m_rd[c]));
            chk({s, ".out_wr_en"},   32'(wr), 32'(m_wr[c]));
            chk({s, ".out_illegal"}, 32'(ill), 32'(m_ill[c]));
            chk({s, ".out_pc"},      pc,      m_pc[c]);
        end
    endtask

    // Compare process: outputs checked mid-cycle, then the model advances on the same inputs.
    always @(negedge clk) begin
        cmp_cfg(0, ready_a, ov_a, rd1_a, rd2_a, ord_a, wr_a, ill_a, pc_a, busy_a);
        cmp_cfg(1, ready_b, ov_b, rd1_b, rd2_b, ord_b, wr_b, ill_b, pc_b, {16'h0, busy_b});
        model_step(0);
        model_step(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic nop, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic wr, input logic [31:0] pc);
        in_valid = v; in_nop = nop; in_rs1 = rs1; in_use_rs1 = u1;
        in_rs2 = rs2; in_use_rs2 = u2; in_rd = rd; in_wr_en = wr; in_pc = pc;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            model_reset(c);
            for (int r = 0; r < 32; r++) m_reg[c][r] = '0;
        end
        rst = 1'b1; out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("reset out_valid", 32'(ov_a), 32'h0);
        chk("reset busy",      busy_a,    32'h0);
        chk("reset out_rd1",   rd1_a,     32'h0);
        chk("reset out_pc",    pc_a,      32'h0);
        chk("reset out_wr_en", 32'(wr_a), 32'h0);
        tick();
        rst = 1'b0;

        for (int i = 1; i < 32; i++) begin
            wb_en = 1'b1; wb_addr = 5'(i); wb_data = 32'hA000_0000 + 32'(i);
            tick();
        end

        // Write-back then a plain operand read.
        wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_en = 1'b0;
        set_in(1, 0, 5, 1, 0, 1, 0, 0, 32'h100);
        tick();
        chk("t1 out_valid", 32'(ov_a), 32'h1);
        chk("t1 out_rd1",   rd1_a,     32'hDEAD_BEEF);
        chk("t1 out_rd2",   rd2_a,     32'h0);
        chk("t1 out_pc",    pc_a,      32'h100);
        chk("t1 b out_rd1", rd1_b,     32'hDEAD_BEEF);

        // RAW interlock with and without bypass.
        set_in(1, 0, 0, 0, 0, 0, 7, 1, 32'h104);
        tick();
        chk("t2 busy a", busy_a, 32'h80);
        chk("t2 busy b", 32'(busy_b), 32'h80);
        set_in(1, 0, 7, 1, 0, 0, 0, 0, 32'h108);
        #1;
        chk("t2 stall a", 32'(ready_a), 32'h0);
        chk("t2 stall b", 32'(ready_b), 32'h0);
        tick();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        #1;
        chk("t2 bypass ready a", 32'(ready_a), 32'h1);
        chk("t2 nobypass ready b", 32'(ready_b), 32'h0);
        tick();
        chk("t2 out_rd1 a", rd1_a,  32'h1234);
        chk("t2 busy a clr", busy_a, 32'h0);
        wb_en = 1'b0;
        #1;
        chk("t2 ready b late", 32'(ready_b), 32'h1);
        tick();
        chk("t2 out_rd1 b", rd1_b, 32'h1234);
        chk("t2 out_pc b",  pc_b,  32'h108);

        // Back-pressure holds the output register.
        set_in(1, 0, 3, 1, 0, 0, 0, 0, 32'h200);
        tick();
        out_ready = 1'b0;
        set_in(1, 0, 4, 1, 0, 0, 0, 0, 32'h300);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3 ready held", 32'(ready_a), 32'h0);
            tick();
            chk("t3 pc held",  pc_a,  32'h200);
            chk("t3 rd1 held", rd1_a, 32'hA000_0003);
        end
        out_ready = 1'b1;
        #1;
        chk("t3 ready release", 32'(ready_a), 32'h1);
        tick();
        chk("t3 next pc",  pc_a,  32'h300);
        chk("t3 next rd1", rd1_a, 32'hA000_0004);

        // NOP stream: consumed, never reaches execute, no scoreboard change.
        set_in(1, 1, 0, 0, 0, 0, 9, 1, 32'h380);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4 nop ready", 32'(ready_a), 32'h1);
            tick();
            chk("t4 nop out_valid", 32'(ov_a), 32'h0);
            chk("t4 nop busy", busy_a, 32'h0);
        end

        // Flush releases the killed writer's scoreboard bit.
        out_ready = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 9, 1, 32'h400);
        tick();
        chk("t5 busy set", busy_a, 32'h200);
        chk("t5 out_rd",   32'(ord_a), 32'h9);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        flush = 1'b1;
        #1;
        chk("t5 flush ready", 32'(ready_a), 32'h0);
        tick();
        flush = 1'b0;
        chk("t5 flush valid", 32'(ov_a), 32'h0);
        chk("t5 flush busy",  busy_a,    32'h0);
        set_in(1, 0, 9, 1, 0, 0, 0, 0, 32'h404);
        #1;
        chk("t5 no stall", 32'(ready_a), 32'h1);
        tick();
        out_ready = 1'b1;

        // Out-of-range indices on the 16-register configuration.
        set_in(1, 0, 20, 1, 0, 0, 0, 0, 32'h500);
        tick();
        chk("t6 illegal b", 32'(ill_b), 32'h1);
        chk("t6 rd1 b",     rd1_b,      32'h0);
        chk("t6 legal a",   32'(ill_a), 32'h0);
        chk("t6 rd1 a",     rd1_a,      32'hA000_0014);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'h55;
        tick();
        wb_en = 1'b0;
        set_in(1, 0, 20, 1, 0, 0, 0, 0, 32'h504);
        tick();
        chk("t6 wb20 a", rd1_a, 32'h55);
        chk("t6 wb20 b", rd1_b, 32'h0);
        set_in(1, 0, 0, 0, 0, 0, 20, 1, 32'h508);
        tick();
        chk("t6 no set b", 32'(busy_b), 32'h0);
        chk("t6 set a",    busy_a,      32'h0010_0000);

        // Reset in the middle of a stall.
        set_in(1, 0, 0, 0, 0, 0, 11, 1, 32'h600);
        tick();
        set_in(1, 0, 11, 1, 0, 0, 0, 0, 32'h604);
        #1;
        chk("t6 stall", 32'(ready_a), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 rst busy a",  busy_a,      32'h0);
        chk("t6 rst busy b",  32'(busy_b), 32'h0);
        chk("t6 rst valid a", 32'(ov_a),   32'h0);

        for (int k = 0; k < 3000; k++) begin
            in_valid   = ($urandom_range(0, 99) < 70);
            in_nop     = ($urandom_range(0, 99) < 10);
            in_rs1     = 5'($urandom_range(0, 19));
            in_rs2     = 5'($urandom_range(0, 19));
            in_rd      = 5'($urandom_range(0, 19));
            in_use_rs1 = ($urandom_range(0, 99) < 60);
            in_use_rs2 = ($urandom_range(0, 99) < 50);
            in_wr_en   = ($urandom_range(0, 99) < 50);
            in_pc      = $urandom;
            out_ready  = ($urandom_range(0, 99) < 75);
            wb_en      = ($urandom_range(0, 99) < 40);
            wb_addr    = 5'($urandom_range(0, 19));
            wb_data    = $urandom;
            flush      = ($urandom_range(0, 99) < 3);
            rst        = ($urandom_range(0, 999) < 5);
            tick();
        end

        rst = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised, pipelined successor to the multi-cycle decode stage.
- Holds the register file, a per-register scoreboard for RAW/WAW interlock, and optional write-back-to-read bypass.
- Emits operands through a valid/ready output register feeding execute.
- NOPs are consumed in decode and never enter execute.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count; 32 = RV32I, 16 = RV32E.
- BYPASS, 1, 1 = forward same-cycle write-back data to operand reads; 0 = stall until the write lands.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decoded fields valid
- in_ready  out  1  decode can accept
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_use_rs1, in_use_rs2  in  1  operand actually read
- in_wr_en  in  1  instruction writes rd
- in_nop  in  1  instruction is a nop
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  execute accepts
- out_rd1, out_rd2  out  XLEN  operand values
- out_rd  out  5  destination register
- out_wr_en  out  1  destination write enable
- out_illegal  out  1  register index >= NREGS
- out_pc  out  XLEN  instruction PC
- wb_en  in  1  write-back strobe
- wb_addr  in  5  write-back register
- wb_data  in  XLEN  write-back value
- flush  in  1  kill the instruction in the output register
- busy  out  NREGS  scoreboard bits, for debug and assertions

Behaviour:
- Reset values:
  - out_valid=0, out_wr_en=0, out_illegal=0, busy=0.
  - out_rd1/out_rd2/out_pc/out_rd=0.
  - Register file contents are not reset, except x0, which is hardwired to 0.
- Accept:
  - acc = in_valid & in_ready.
  - in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Hazard, combinational, evaluated only when !in_nop:
  - use_rsN & rsN!=0 & busy[rsN] & !(BYPASS & wb_en & wb_addr==rsN), for N = 1, 2; or
  - in_wr_en & in_rd!=0 & busy[in_rd] (WAW stall).
- NOP: when acc & in_nop, the instruction is consumed.
  - out_valid becomes 0 if out_ready fired, otherwise it holds.
  - Scoreboard unchanged. This is a 1-cycle bubble, equivalent to the old fetch shortcut.
- Non-NOP acc: the output register loads next edge.
  - out_valid=1.
  - out_rdN = rsN==0 ? 0 : (BYPASS & wb_en & wb_addr==rsN) ? wb_data : regfile[rsN].
  - out_pc, out_rd and out_wr_en are copied from the inputs.
- Latency: 1 cycle from acc to out_valid.
- Back-pressure: out_valid & !out_ready holds all out_* stable.
- Scoreboard:
  - Set busy[in_rd] on non-NOP acc with in_wr_en & in_rd!=0.
  - Clear busy[wb_addr] on wb_en.
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is always 0.
- Register file: written on wb_en & wb_addr!=0 & wb_addr<NREGS. Writes and reads are otherwise independent; there is no internal write-before-read ordering except through BYPASS.
- Illegal indices: any used rsN, or rd with wr_en, >= NREGS gives out_illegal=1.
  - Operand value for that index is 0.
  - Scoreboard is not set.
  - Writes with wb_addr >= NREGS are ignored.
- Flush (synchronous, highest priority below rst):
  - Next edge, out_valid=0.
  - If out_valid & out_wr_en & out_rd!=0, clear busy[out_rd]. This is safe because WAW stalls guarantee a unique writer.
  - in_ready=0 during flush, so there is no simultaneous accept.
- rst mid-operation: all state returns to reset values on the next edge; in-flight write-backs are dropped.

Decomposition:
- Package decode_pkg:
  - XLEN default.
  - REG_IDX_W=5.
  - Typedef dec_out_t {rd1, rd2, rd, wr_en, illegal, pc}.
  - Existing CTRL_STATE_* constants remain in ctrl_states.svh.
- Sub-module scoreboard: NREGS-bit busy vector with set/clear/flush-clear ports and the set-wins rule.
- Existing reg_file is re-parametrised by XLEN/NREGS and instantiated unchanged in function.

Test Plan:
1. wb_en x5=0xDEADBEEF, then decode rs1=5, use_rs1=1 -> next cycle out_valid=1, out_rd1=0xDEADBEEF; rs2=0 -> out_rd2=0.
2. Issue rd=7 wr_en, then rs1=7 with no wb -> in_ready=0 held; wb x7=0x1234 same cycle as retry, BYPASS=1 -> accept, out_rd1=0x1234, busy[7]=0. Same with BYPASS=0 -> stall one more cycle.
3. out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> next instruction loads next edge.
4. in_nop=1 stream of 4 -> out_valid stays 0, busy unchanged, in_ready=1 each cycle.
5. Output reg holds rd=9 wr_en, flush=1 -> out_valid=0, busy[9]=0; a later rs1=9 decode does not stall.
6. NREGS=16: rs1=20 -> out_illegal=1, out_rd1=0; wb x20 ignored; rst asserted mid-stall -> busy=0, out_valid=0.
